// File: rtl/ula_pkg.sv
// Shared definitions for the ALU input sequencer: FSM state codes, datapath widths
// and the default debounce length.
package ula_pkg;

    localparam int LARG_OPERANDO     = 8;
    localparam int LARG_OPCODE       = 3;
    localparam int DEB_CICLOS_PADRAO = 500000;

    typedef enum logic [2:0] {
        ESPERA_A  = 3'd0,
        ESPERA_B  = 3'd1,
        ESPERA_OP = 3'd2,
        EXECUTA   = 3'd3,
        MOSTRA    = 3'd4
    } estado_t;

endpackage

// File: rtl/filtro_botao.sv
// Confirm-key conditioning: 2-FF synchronizer, optional debounce filter (ULA_DEBOUNCE_EN)
// and falling-edge detector producing a 1-cycle press pulse.
module filtro_botao #(
    parameter int DEB_CICLOS = ula_pkg::DEB_CICLOS_PADRAO
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_ok,
    output logic press
);

    logic       r_sync1;
    logic       r_sync2;
    logic [1:0] r_valido;
    logic       r_hist;
    logic       r_armado;
    logic       w_nivel;

    if (DEB_CICLOS < 2) begin : g_deb_invalido
        $error("filtro_botao: DEB_CICLOS must be >= 2");
    end

    // NOTE: sequential state is written with non-blocking assignments so every flop
    // samples the pre-edge values of the others; blocking here would collapse the chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= 1'b1;
            r_sync2  <= 1'b1;
            r_valido <= '0;
        end else begin
            r_sync1  <= key_ok;
            r_sync2  <= r_sync1;
            r_valido <= {r_valido[0], 1'b1};
        end
    end

`ifdef ULA_DEBOUNCE_EN
    localparam int LARG_CNT = $clog2(DEB_CICLOS + 1);

    logic [LARG_CNT-1:0] r_cnt;
    logic                r_filtro;

    // Accept a new level only after DEB_CICLOS consecutive cycles of disagreement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_filtro <= 1'b1;
        end else if (r_sync2 == r_filtro) begin
            r_cnt <= '0;
        end else if (r_cnt == LARG_CNT'(DEB_CICLOS - 1)) begin
            r_cnt    <= '0;
            r_filtro <= r_sync2;
        end else begin
            r_cnt <= r_cnt + LARG_CNT'(1);
        end
    end

    assign w_nivel = r_filtro;
`else
    assign w_nivel = r_sync2;
`endif

    // Arm only once a genuine released level has crossed the synchronizer, so a key
    // held through reset cannot masquerade as a fresh press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hist   <= 1'b1;
            r_armado <= 1'b0;
        end else begin
            r_hist <= w_nivel;
            if (r_valido[1] && r_sync2) begin
                r_armado <= 1'b1;
            end
        end
    end

    assign press = r_armado & r_hist & ~w_nivel;

endmodule

// File: rtl/ula_ctrl_entrada.sv
// Operand/opcode sequencer for the 8-bit ALU: one confirm press per field, then latch
// the result mux output for display. Debounce is enabled with ULA_DEBOUNCE_EN.
module ula_ctrl_entrada
    import ula_pkg::*;
#(
    parameter int DEB_CICLOS = DEB_CICLOS_PADRAO
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [LARG_OPERANDO-1:0] sw,
    input  logic                     key_ok,
    input  logic [LARG_OPERANDO-1:0] resultado_mux,
    output logic [LARG_OPERANDO-1:0] op_a,
    output logic [LARG_OPERANDO-1:0] op_b,
    output logic [LARG_OPCODE-1:0]   sel,
    output logic [LARG_OPERANDO-1:0] resultado,
    output logic                     pronto,
    output logic [2:0]               estado
);

    estado_t                  r_estado;
    estado_t                  w_prox;
    logic                     w_press;
    logic                     w_carrega_a;
    logic                     w_carrega_b;
    logic                     w_carrega_op;
    logic                     w_executa;
    logic                     w_limpa;
    logic [LARG_OPERANDO-1:0] r_op_a;
    logic [LARG_OPERANDO-1:0] r_op_b;
    logic [LARG_OPCODE-1:0]   r_sel;
    logic [LARG_OPERANDO-1:0] r_resultado;
    logic                     r_pronto;

    filtro_botao #(
        .DEB_CICLOS (DEB_CICLOS)
    ) u_filtro_botao (
        .clk    (clk),
        .rst_n  (rst_n),
        .key_ok (key_ok),
        .press  (w_press)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado <= ESPERA_A;
        end else begin
            r_estado <= w_prox;
        end
    end

    // NOTE: every always_comb output is given a default first, so no path leaves a
    // signal unassigned and no latch is inferred.
    always_comb begin
        w_prox       = r_estado;
        w_carrega_a  = 1'b0;
        w_carrega_b  = 1'b0;
        w_carrega_op = 1'b0;
        w_executa    = 1'b0;
        w_limpa      = 1'b0;
        case (r_estado)
            ESPERA_A: if (w_press) begin
                w_carrega_a = 1'b1;
                w_prox      = ESPERA_B;
            end
            ESPERA_B: if (w_press) begin
                w_carrega_b = 1'b1;
                w_prox      = ESPERA_OP;
            end
            ESPERA_OP: if (w_press) begin
                w_carrega_op = 1'b1;
                w_prox       = EXECUTA;
            end
            EXECUTA: begin
                w_executa = 1'b1;
                w_prox    = MOSTRA;
            end
            MOSTRA: if (w_press) begin
                w_limpa = 1'b1;
                w_prox  = ESPERA_A;
            end
            default: w_prox = ESPERA_A;
        endcase
    end

    // Presses landing in EXECUTA are dropped because that state ignores w_press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_sel       <= '0;
            r_resultado <= '0;
            r_pronto    <= 1'b0;
        end else begin
            if (w_carrega_a)  r_op_a <= sw;
            if (w_carrega_b)  r_op_b <= sw;
            if (w_carrega_op) r_sel  <= sw[LARG_OPCODE-1:0];
            if (w_executa) begin
                r_resultado <= resultado_mux;
                r_pronto    <= 1'b1;
            end
            if (w_limpa) r_pronto <= 1'b0;
        end
    end

    assign op_a      = r_op_a;
    assign op_b      = r_op_b;
    assign sel       = r_sel;
    assign resultado = r_resultado;
    assign pronto    = r_pronto;
    assign estado    = r_estado;

endmodule

// File: tb/tb_ula_ctrl_entrada.sv
// Scoreboard bench for ula_ctrl_entrada: a press-level model pushes expected output
// snapshots; a monitor compares them whenever estado changes and checks holds otherwise.
module tb_ula_ctrl_entrada;
    import ula_pkg::*;

    localparam int DEB = 4;
`ifdef ULA_DEBOUNCE_EN
    localparam int LAT = DEB + 3;
`else
    localparam int LAT = 3;
`endif
    localparam int GAP_MIN = DEB + 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       key_ok = 1'b1;
    logic [7:0] sw = 8'h00;
    logic [7:0] resultado_mux;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic [2:0] sel;
    logic [7:0] resultado;
    logic       pronto;
    logic [2:0] estado;

    typedef struct packed {
        logic [2:0] est;
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] sel;
        logic [7:0] res;
        logic       pronto;
    } obs_t;

    obs_t fila[$];
    int   n_comp = 0;
    int   n_falha = 0;

    // Reference model state, one step per accepted press.
    int         m_fase = 0;
    logic [7:0] m_a = 8'h00;
    logic [7:0] m_b = 8'h00;
    logic [2:0] m_sel = 3'd0;
    logic [7:0] m_res = 8'h00;
    logic       m_pronto = 1'b0;

    always #5 clk = ~clk;

    ula_ctrl_entrada #(
        .DEB_CICLOS (DEB)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sw            (sw),
        .key_ok        (key_ok),
        .resultado_mux (resultado_mux),
        .op_a          (op_a),
        .op_b          (op_b),
        .sel           (sel),
        .resultado     (resultado),
        .pronto        (pronto),
        .estado        (estado)
    );

    function automatic logic [7:0] ula_ref(input logic [7:0] a, input logic [7:0] b,
                                           input logic [2:0] s);
        case (s)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a + b;
            3'd3:    return a - b;
            3'd4:    return a ^ b;
            3'd5:    return ~a;
            3'd6:    return a << 1;
            default: return a >> 1;
        endcase
    endfunction

    assign resultado_mux = ula_ref(op_a, op_b, sel);

    task automatic check(input string nome, input logic [63:0] atual, input logic [63:0] req);
        n_comp++;
        if (atual !== req) begin
            n_falha++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nome, atual, req);
        end
    endtask

    function automatic obs_t modelo_obs(input logic [2:0] e);
        obs_t o;
        o.est    = e;
        o.a      = m_a;
        o.b      = m_b;
        o.sel    = m_sel;
        o.res    = m_res;
        o.pronto = m_pronto;
        return o;
    endfunction

    task automatic modelo_press(input logic [7:0] v);
        case (m_fase)
            0: begin
                m_a = v;
                m_fase = 1;
                fila.push_back(modelo_obs(3'd1));
            end
            1: begin
                m_b = v;
                m_fase = 2;
                fila.push_back(modelo_obs(3'd2));
            end
            2: begin
                m_sel = v[2:0];
                fila.push_back(modelo_obs(3'd3));
                m_res = ula_ref(m_a, m_b, m_sel);
                m_pronto = 1'b1;
                m_fase = 4;
                fila.push_back(modelo_obs(3'd4));
            end
            default: begin
                m_pronto = 1'b0;
                m_fase = 0;
                fila.push_back(modelo_obs(3'd0));
            end
        endcase
    endtask

    task automatic modelo_reset();
        m_a = 8'h00;
        m_b = 8'h00;
        m_sel = 3'd0;
        m_res = 8'h00;
        m_pronto = 1'b0;
        m_fase = 0;
    endtask

    task automatic espera_livre();
        key_ok = 1'b1;
        repeat (GAP_MIN + $urandom_range(0, 4)) begin
            @(negedge clk);
            #1 sw = 8'($urandom);
        end
    endtask

    task automatic mede_latencia(input string nome, input logic [2:0] antes);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            n++;
            #1;
        end while (estado === antes && n < 200);
        check(nome, 64'(n), 64'(LAT));
    endtask

    // One confirmed press: sw stays put until the capture edge, then wanders.
    task automatic pressiona(input logic [7:0] v, input int segurar, input string nome);
        logic [2:0] antes;
        @(negedge clk);
        #1;
        antes = 3'(m_fase);
        modelo_press(v);
        sw = v;
        key_ok = 1'b0;
        mede_latencia({nome, "_latency"}, antes);
        repeat (segurar) begin
            @(negedge clk);
            #1 sw = 8'($urandom);
        end
        espera_livre();
    endtask

    // Monitor: every estado change must match the next queued snapshot; between
    // changes all outputs must hold the last one.
    initial begin
        obs_t       atual;
        obs_t       ref_atual;
        logic [2:0] est_ant;
        ref_atual = '0;
        est_ant = 3'd0;
        forever begin
            @(negedge clk);
            atual = {estado, op_a, op_b, sel, resultado, pronto};
            if (atual.est !== est_ant) begin
                if (fila.size() == 0) begin
                    check("unexpected_transition", 64'(atual), 64'(ref_atual));
                end else begin
                    ref_atual = fila.pop_front();
                    check("transition", 64'(atual), 64'(ref_atual));
                end
                est_ant = atual.est;
            end else begin
                check("hold", 64'(atual), 64'(ref_atual));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] v;
        logic [2:0] antes;

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        check("reset_estado", 64'(estado), 64'(0));
        check("reset_op_a", 64'(op_a), 64'(0));
        check("reset_pronto", 64'(pronto), 64'(0));

        // Directed sequence with A+B selected.
        pressiona(8'h3C, 2, "seq_a");
        pressiona(8'h05, 3, "seq_b");
        pressiona(8'h02, 1, "seq_op");
        check("seq_op_a", 64'(op_a), 64'(8'h3C));
        check("seq_op_b", 64'(op_b), 64'(8'h05));
        check("seq_sel", 64'(sel), 64'(2));
        check("seq_resultado", 64'(resultado), 64'(8'h41));
        check("seq_pronto", 64'(pronto), 64'(1));
        check("seq_estado", 64'(estado), 64'(4));
        pressiona(8'($urandom), 2, "seq_fifth");
        check("fifth_estado", 64'(estado), 64'(0));
        check("fifth_pronto", 64'(pronto), 64'(0));
        check("fifth_op_a_held", 64'(op_a), 64'(8'h3C));
        check("fifth_resultado_held", 64'(resultado), 64'(8'h41));

        // Long hold gives exactly one transition.
        pressiona(8'($urandom), 50, "hold50");
        check("hold50_estado", 64'(estado), 64'(1));
        pressiona(8'($urandom), 2, "hold50_b");
        pressiona(8'($urandom), 2, "hold50_op");
        pressiona(8'($urandom), 2, "hold50_clr");

`ifdef ULA_DEBOUNCE_EN
        // Bouncing key: nothing until the level settles low.
        @(negedge clk);
        #1;
        antes = 3'(m_fase);
        v = 8'($urandom);
        modelo_press(v);
        sw = v;
        for (int i = 0; i < 10; i++) begin
            key_ok = (i % 2) != 0;
            repeat (2) @(posedge clk);
            #1;
        end
        check("bounce_quiet", 64'(estado), 64'(antes));
        key_ok = 1'b0;
        mede_latencia("bounce_latency", antes);
        espera_livre();
        pressiona(8'($urandom), 2, "bounce_b");
        pressiona(8'($urandom), 2, "bounce_op");
        pressiona(8'($urandom), 2, "bounce_clr");
`endif

        // Random sequences; one opcode press uses sw=0xFF.
        for (int s = 0; s < 6; s++) begin
            pressiona(8'($urandom), $urandom_range(1, 6), "rnd_a");
            pressiona(8'($urandom), $urandom_range(1, 6), "rnd_b");
            v = (s == 2) ? 8'hFF : 8'($urandom);
            pressiona(v, $urandom_range(1, 6), "rnd_op");
            if (s == 2) check("sel_ff", 64'(sel), 64'(7));
            check("rnd_resultado", 64'(resultado), 64'(ula_ref(op_a, op_b, sel)));
            pressiona(8'($urandom), $urandom_range(1, 6), "rnd_clr");
        end

        // Asynchronous reset in ESPERA_OP with the key going down.
        pressiona(8'($urandom), 2, "rst_a");
        pressiona(8'($urandom), 2, "rst_b");
        @(negedge clk);
        #1 key_ok = 1'b0;
        @(posedge clk);
        #3;
        modelo_reset();
        fila.push_back(modelo_obs(3'd0));
        rst_n = 1'b0;
        #1;
        check("async_rst_estado", 64'(estado), 64'(0));
        check("async_rst_ops", 64'({op_a, op_b, sel}), 64'(0));
        check("async_rst_out", 64'({resultado, pronto}), 64'(0));
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        check("rst_held_no_press", 64'(estado), 64'(0));
        espera_livre();
        pressiona(8'($urandom), 2, "post_rst_a");
        check("post_rst_estado", 64'(estado), 64'(1));
        pressiona(8'($urandom), 2, "post_rst_b");
        pressiona(8'($urandom), 2, "post_rst_op");

        // Illegal state from MOSTRA: back to ESPERA_A, registers untouched.
        @(posedge clk);
        fila.push_back(modelo_obs(3'd6));
        fila.push_back(modelo_obs(3'd0));
        m_fase = 0;
        #2 force dut.r_estado = estado_t'(3'd6);
        #1 release dut.r_estado;
        repeat (2) @(negedge clk);
        #1;
        check("illegal_estado", 64'(estado), 64'(0));
        check("illegal_regs", 64'({op_a, op_b, sel, resultado, pronto}),
              64'({m_a, m_b, m_sel, m_res, m_pronto}));
        pressiona(8'($urandom), 2, "after_illegal_a");
        pressiona(8'($urandom), 2, "after_illegal_b");
        pressiona(8'($urandom), 2, "after_illegal_op");
        pressiona(8'($urandom), 2, "after_illegal_clr");

        repeat (10) @(negedge clk);
        #1;
        check("queue_drained", 64'(fila.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_comp, n_falha);
        $finish;
    end

endmodule

// File: doc/ula_ctrl_entrada.md
# ula_ctrl_entrada

Operand and opcode sequencer for the 8-bit ALU on the FPGA board. It captures operand A, operand B and the 3-bit opcode from the board switches, one per press of a single confirm key. It drives the registered operands and the opcode selector into the ALU datapath and the 8-to-1 result mux, then latches the selected mux output for display. It sits directly upstream of the result mux and also closes the loop on its output.

## Interface
Parameters:
- DEB_CICLOS, 500000, number of cycles the key must stay stable before a level change is accepted (10 ms at 50 MHz); used only with debounce compiled in; must be ≥ 2.

Ports:
- clk  input  1  board clock; single clock domain.
- rst_n  input  1  reset, asynchronous, active-low.
- sw  input  8  board switches; these are operand/opcode data and are sampled only on a confirmed press.
- key_ok  input  1  raw confirm key; active-low, where 0 means pressed; asynchronous to clk.
- resultado_mux  input  8  combinational output of the 8-to-1 result mux.
- op_a  output  8  registered operand A to the ALU.
- op_b  output  8  registered operand B to the ALU.
- sel  output  3  registered opcode selector to the result mux.
- resultado  output  8  latched ALU result for display.
- pronto  output  1  high while `resultado` is valid.
- estado  output  3  current FSM state code, for LEDs.

## Operation
- **Key path:**
  - `key_ok` passes through a 2-FF synchronizer; both flops reset to 1.
  - An optional debounce filter follows the synchronizer.
  - A press is a 1-cycle pulse on the 1→0 transition of the filtered level.
  - The history flop resets to 1, so no press is generated out of reset.
  - Holding the key produces exactly one press; releasing it produces none.
- **FSM, with state codes:**
  - ESPERA_A (0): on press, op_a←sw and go to ESPERA_B.
  - ESPERA_B (1): on press, op_b←sw and go to ESPERA_OP.
  - ESPERA_OP (2): on press, sel←sw[2:0] (sw[7:3] ignored) and go to EXECUTA.
  - EXECUTA (3): unconditional, 1 cycle. resultado←resultado_mux, pronto←1, go to MOSTRA. Presses arriving in this cycle are dropped.
  - MOSTRA (4): on press, pronto←0 and go to ESPERA_A. op_a, op_b, sel and resultado keep their values until overwritten.
  - Codes 5–7 are illegal and return to ESPERA_A on the next edge, with no register changes.
- Registers change only on the listed transitions. `sw` changes outside a press have no effect.
- Reset, asserted at any time including mid-sequence, forces:
  - estado=0, op_a=0, op_b=0, sel=0, resultado=0, pronto=0;
  - synchronizer and filter state to the released level, debounce counter to 0.

## Timing
- Without debounce: if key_ok goes low before edge k, the press pulse is high during the cycle after edge k+1, and the target register updates at edge k+2.
- With debounce: the accepted level changes after DEB_CICLOS consecutive cycles of a stable synchronized level. Any bounce restarts the count, and latency grows by DEB_CICLOS cycles.
- The mux settling path is 1 cycle: sel updates at the ESPERA_OP→EXECUTA edge, and resultado samples the mux output at the following edge.
- pronto rises on the same edge that loads resultado and falls on the MOSTRA→ESPERA_A edge.
- Minimum of 1 cycle between consecutive presses; each press causes at most one transition.

## Configuration
- ULA_DEBOUNCE_EN defined: the filter counter (width $clog2(DEB_CICLOS+1)) is instantiated between the synchronizer and the edge detector.
- ULA_DEBOUNCE_EN undefined: the synchronizer feeds the edge detector directly, no counter is present, and DEB_CICLOS is unused. This build is for simulation and for pre-debounced inputs.

## Structure
- Shared package `ula_pkg` holds:
  - the state codes ESPERA_A..MOSTRA;
  - the operand width (8) and opcode width (3);
  - the default DEB_CICLOS.
- Sub-module `filtro_botao` covers the synchronizer, the optional debounce filter and the edge detector, and outputs a 1-cycle `press` pulse. The FSM and datapath registers stay in `ula_ctrl_entrada`.

## Test plan
Run the bench with DEB_CICLOS=4, once with debounce compiled in and once without.
- Full sequence: press with sw=0x3C, then 0x05, then 0x02, with the mux model returning A+B. Expect op_a=0x3C, op_b=0x05, sel=2, resultado=0x41, pronto=1, estado=4. A fifth press gives estado=0 and pronto=0, with operands held.
- Key held low for 50 cycles in ESPERA_A: exactly one transition, estado=1. No further change on release.
- Debounce build, key toggling every 2 cycles for 20 cycles and then held low: no press during the toggling, and one press DEB_CICLOS+3 cycles after the level settles.
- sw changed repeatedly between presses, and sw=0xFF at the opcode press: only press-time values are captured, and sel=7.
- rst_n pulsed low asynchronously while in ESPERA_OP with the key held: all outputs are 0 and estado=0 immediately. After release, no press is generated until the key goes high and then low again.
- Illegal state 6 forced via the bench: estado=0 on the next edge, and op_a/op_b/sel/resultado are unchanged.
